usb_tx_packet_gen: RTL and testbench

- Transmit-side packet generator for the USB transceiver.
- Reads the buffered payload out of data_buffer and frames it as a byte stream: SYNC, PID, payload, CRC16.
- Delivers bytes over a valid/ready handshake to the bit-level TX encoder (NRZI/bit-stuff), then requests EOP.
- It is the reader at the far end of the data_buffer interface.

---
 rtl/usb_pkg.sv | 50 +++++
 rtl/usb_tx_packet_gen_if.sv | 10 +
 rtl/usb_crc16.sv | 23 ++
 rtl/usb_tx_packet_gen.sv | 148 ++++++++++++++
 tb/tb_usb_tx_packet_gen.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// Shared USB transceiver types, constants and CRC16 helper.
// Used by both the TX packet generator and the RX-side checker.
package usb_pkg;

  typedef enum logic [3:0] {
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_STALL = 4'hE
  } pid_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_EOP,
    ST_DONE
  } tx_state_t;

  localparam logic [7:0]  SYNC_BYTE    = 8'h80;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;

  function automatic logic pid_legal(input logic [3:0] p);
    case (p)
      PID_ACK, PID_DATA0, PID_NAK, PID_DATA1, PID_STALL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic pid_is_data(input logic [3:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

  // Reflected CRC16 over one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0]) r = (r >> 1) ^ CRC16_POLY_R;
      else      r = r >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_tx_packet_gen_if.sv
// Byte stream from the packet generator to the bit-level TX encoder.
interface usb_tx_packet_gen_if;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic       tx_byte_ready;
  logic       tx_eop;

  modport master (output tx_byte, output tx_byte_valid, output tx_eop, input tx_byte_ready);
  modport slave  (input tx_byte, input tx_byte_valid, input tx_eop, output tx_byte_ready);
endinterface

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 accumulator; one byte per enabled cycle.
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_crc <= CRC16_INIT;
    else if (i_clr) r_crc <= CRC16_INIT;
    else if (i_en)  r_crc <= crc16_byte(r_crc, i_data);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/usb_tx_packet_gen.sv
// USB TX packet framer: SYNC, PID, payload from data_buffer, CRC16, then EOP.
module usb_tx_packet_gen
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64,
  parameter int OCC_W       = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tx_start,
  input  logic [3:0]         i_tx_pid,
  input  logic [OCC_W-1:0]   i_buffer_occupancy,
  input  logic [7:0]         i_tx_data,
  output logic               o_get_tx_data,
  usb_tx_packet_gen_if.master enc,
  output logic               o_tx_busy,
  output logic               o_tx_done,
  output logic               o_tx_err
);

  localparam logic [OCC_W-1:0] ONE     = OCC_W'(1);
  localparam logic [OCC_W-1:0] MAX_LEN = OCC_W'(MAX_PAYLOAD);

  tx_state_t        r_state;
  logic [3:0]       r_pid;
  logic [OCC_W-1:0] r_len;
  logic [OCC_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_eop;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_xfer;
  logic             w_pop;
  logic             w_crc_clr;
  logic [15:0]      w_crc;
  logic [7:0]       w_byte;
  logic [OCC_W-1:0] w_len;

  assign w_len     = (i_buffer_occupancy > MAX_LEN) ? MAX_LEN : i_buffer_occupancy;
  assign w_xfer    = r_valid & enc.tx_byte_ready;
  assign w_pop     = w_xfer & (r_state == ST_DATA);
  assign w_crc_clr = (r_state == ST_IDLE) & i_tx_start;

  usb_crc16 u_crc (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_crc_clr),
    .i_en   (w_pop),
    .i_data (i_tx_data),
    .o_crc  (w_crc)
  );

  // Byte is selected by the registered state; payload passes straight from the
  // FWFT head, which only moves on a pop, so it holds steady under backpressure.
  always_comb begin
    w_byte = '0;
    case (r_state)
      ST_SYNC:   w_byte = SYNC_BYTE;
      ST_PID:    w_byte = {~r_pid, r_pid};
      ST_DATA:   w_byte = i_tx_data;
      ST_CRC_LO: w_byte = ~w_crc[7:0];
      ST_CRC_HI: w_byte = ~w_crc[15:8];
      default:   w_byte = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pid   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_eop   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_eop  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_tx_start) begin
            if (pid_legal(i_tx_pid)) begin
              r_pid   <= i_tx_pid;
              r_len   <= w_len;
              r_cnt   <= '0;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= ST_SYNC;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_SYNC: if (w_xfer) r_state <= ST_PID;
        ST_PID: begin
          if (w_xfer) begin
            if (!pid_is_data(r_pid)) begin
              r_valid <= 1'b0;
              r_eop   <= 1'b1;
              r_state <= ST_EOP;
            end else if (r_len == '0) begin
              r_state <= ST_CRC_LO;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + ONE;
            if (r_cnt + ONE == r_len) r_state <= ST_CRC_LO;
          end
        end
        ST_CRC_LO: if (w_xfer) r_state <= ST_CRC_HI;
        ST_CRC_HI: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
            r_eop   <= 1'b1;
            r_state <= ST_EOP;
          end
        end
        ST_EOP: begin
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign enc.tx_byte       = w_byte;
  assign enc.tx_byte_valid = r_valid;
  assign enc.tx_eop        = r_eop;
  assign o_get_tx_data     = w_pop;
  assign o_tx_busy         = r_busy;
  assign o_tx_done         = r_done;
  assign o_tx_err          = r_err;

endmodule

// File: tb/tb_usb_tx_packet_gen.sv
// Directed bench for usb_tx_packet_gen: vector table plus backpressure and reset sequences.
module tb_usb_tx_packet_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pid = 4'h0;
  logic [6:0] occ = 7'd0;
  logic [7:0] tx_data;
  logic       get, busy, done, err;

  usb_tx_packet_gen_if bus ();

  usb_tx_packet_gen #(.MAX_PAYLOAD(64), .OCC_W(7)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_tx_start         (start),
    .i_tx_pid           (pid),
    .i_buffer_occupancy (occ),
    .i_tx_data          (tx_data),
    .o_get_tx_data      (get),
    .enc                (bus.master),
    .o_tx_busy          (busy),
    .o_tx_done          (done),
    .o_tx_err           (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Encoder ready: tied high or random
  bit rand_ready = 1'b0;
  initial bus.tx_byte_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.tx_byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // data_buffer model: FWFT head advanced by pops
  logic [7:0] payload [0:1023];
  int pidx = 0;
  assign tx_data = payload[pidx];
  always @(posedge clk) if (get) pidx <= pidx + 1;

  // Monitor (sampled on falling edge)
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] cap_q[$];
  int pop_idx_q[$];
  int npops = 0, neop = 0, ndone = 0, nerr = 0, nbusy = 0, norphan = 0;
  int last_xfer_cyc = 0, eop_cyc = 0, done_cyc = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  always @(negedge clk) begin
    if (prev_stall && !rst) begin
      check("hold_valid", bus.tx_byte_valid, 1);
      check("hold_byte", bus.tx_byte, prev_byte);
    end
    prev_stall = bus.tx_byte_valid && !bus.tx_byte_ready;
    prev_byte  = bus.tx_byte;
    if (bus.tx_byte_valid && bus.tx_byte_ready) begin
      cap_q.push_back(bus.tx_byte);
      last_xfer_cyc = cyc;
    end
    if (get) begin
      npops++;
      pop_idx_q.push_back(cap_q.size());
      if (!(bus.tx_byte_valid && bus.tx_byte_ready)) norphan++;
    end
    if (bus.tx_eop) begin neop++; eop_cyc = cyc; end
    if (done) begin ndone++; done_cyc = cyc; end
    if (err) nerr++;
    if (busy) nbusy++;
  end

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  logic [7:0] exp_q[$];

  task automatic run_packet(input string nm, input logic [3:0] p, input logic [6:0] o,
                            input bit exp_err, input int exp_pops, input bit poke);
    int bc, bp, bpq, be, bd, br, bb, bo;
    bit fin;
    bc = cap_q.size(); bp = npops; bpq = pop_idx_q.size();
    be = neop; bd = ndone; br = nerr; bb = nbusy; bo = norphan;
    @(posedge clk); #1;
    pid = p; occ = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; occ = 7'h7F;
    fin = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      if (poke && k == 4) begin start = 1'b1; pid = 4'h5; occ = 7'd3; end
      if (poke && k == 5) start = 1'b0;
      if (exp_err ? (nerr != br) : (ndone != bd)) fin = 1'b1;
      else begin @(posedge clk); #1; end
    end
    start = 1'b0;
    check({nm, "_finished"}, fin, 1);
    if (exp_err) begin
      repeat (3) @(posedge clk);
      #1;
      check({nm, "_err_pulses"}, nerr - br, 1);
      check({nm, "_no_bytes"}, cap_q.size() - bc, 0);
      check({nm, "_busy_cycles"}, nbusy - bb, 0);
      check({nm, "_no_eop"}, neop - be, 0);
    end else begin
      check({nm, "_busy_after"}, busy, 0);
      check({nm, "_done_1cyc"}, done, 0);
      check({nm, "_no_err"}, nerr - br, 0);
      check({nm, "_nbytes"}, cap_q.size() - bc, exp_q.size());
      for (int i = 0; i < exp_q.size() && bc + i < cap_q.size(); i++)
        check({nm, $sformatf("_byte%0d", i)}, cap_q[bc + i], exp_q[i]);
      check({nm, "_pops"}, npops - bp, exp_pops);
      check({nm, "_orphan_pops"}, norphan - bo, 0);
      for (int j = 0; j < exp_pops && bpq + j < pop_idx_q.size(); j++)
        check({nm, $sformatf("_pop%0d_at", j)}, pop_idx_q[bpq + j] - bc, 3 + j);
      check({nm, "_eop_count"}, neop - be, 1);
      check({nm, "_eop_timing"}, eop_cyc - last_xfer_cyc, 1);
      check({nm, "_done_timing"}, done_cyc - eop_cyc, 1);
    end
  endtask

  typedef struct {
    string           name;
    logic [3:0]      pid;
    logic [6:0]      occ;
    int              nexp;
    logic [4:0][7:0] exp;
    bit              err;
    int              pops;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [3:0] p, input logic [6:0] o, input int ne,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input bit e, input int pp);
    vec_t v;
    v.name = n; v.pid = p; v.occ = o; v.nexp = ne;
    v.exp[0] = b0; v.exp[1] = b1; v.exp[2] = b2; v.exp[3] = b3; v.exp[4] = b4;
    v.err = e; v.pops = pp;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    logic [15:0] crc;
    int base, cap0, pops0, eop0;
    bit seen;

    vecs[0] = mk("ack",    4'h2, 7'd0, 2, 8'h80, 8'hD2, 8'h00, 8'h00, 8'h00, 0, 0);
    vecs[1] = mk("nak",    4'hA, 7'd5, 2, 8'h80, 8'h5A, 8'h00, 8'h00, 8'h00, 0, 0);
    vecs[2] = mk("stall",  4'hE, 7'd0, 2, 8'h80, 8'h1E, 8'h00, 8'h00, 8'h00, 0, 0);
    vecs[3] = mk("data0z", 4'h3, 7'd0, 4, 8'h80, 8'hC3, 8'h00, 8'h00, 8'h00, 0, 0);
    vecs[4] = mk("data1b", 4'hB, 7'd1, 5, 8'h80, 8'h4B, 8'h00, 8'h40, 8'hBF, 0, 1);
    vecs[5] = mk("data0b", 4'h3, 7'd1, 5, 8'h80, 8'hC3, 8'h00, 8'h40, 8'hBF, 0, 1);
    vecs[6] = mk("ill5",   4'h5, 7'd3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
    vecs[7] = mk("ill0",   4'h0, 7'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);

    for (int i = 0; i < 1024; i++) payload[i] = 8'h00;

    #2;
    check("rst_valid", bus.tx_byte_valid, 0);
    check("rst_byte", bus.tx_byte, 0);
    check("rst_eop", bus.tx_eop, 0);
    check("rst_get", get, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 8; v++) begin
      exp_q.delete();
      for (int i = 0; i < vecs[v].nexp; i++) exp_q.push_back(vecs[v].exp[i]);
      run_packet(vecs[v].name, vecs[v].pid, vecs[v].occ, vecs[v].err, vecs[v].pops, 1'b0);
    end

    // 64-byte DATA0 under random backpressure, occupancy capped, start poked mid-packet
    base = pidx;
    for (int k = 0; k < 64; k++) payload[base + k] = 8'($urandom);
    for (int k = 64; k < 80; k++) payload[base + k] = 8'hEE;
    crc = 16'hFFFF;
    exp_q.delete();
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hC3);
    for (int k = 0; k < 64; k++) begin
      exp_q.push_back(payload[base + k]);
      crc = crc_model(crc, payload[base + k]);
    end
    exp_q.push_back(~crc[7:0]);
    exp_q.push_back(~crc[15:8]);
    rand_ready = 1'b1;
    run_packet("bp64", 4'h3, 7'd70, 1'b0, 64, 1'b1);
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset mid-DATA aborts without EOP or further pops
    for (int k = 0; k < 16; k++) payload[pidx + k] = 8'(k + 1);
    @(posedge clk); #1;
    pid = 4'h3; occ = 7'd10; start = 1'b1;
    pops0 = npops;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (npops - pops0 >= 3) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("rstmid_reached_data", seen, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_valid", bus.tx_byte_valid, 0);
    check("rstmid_byte", bus.tx_byte, 0);
    check("rstmid_get", get, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_eop", bus.tx_eop, 0);
    cap0 = npops; eop0 = neop;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_no_more_pops", npops - cap0, 0);
    check("rstmid_no_eop", neop - eop0, 0);
    check("rstmid_idle_busy", busy, 0);

    exp_q.delete();
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hD2);
    run_packet("ack_after_rst", 4'h2, 7'd4, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
